// File: rtl/stereo_channel_mixer.sv
// Stereo channel mixer: after the operator pipeline signals a finished sample,
// walk every channel, build its output from the operator pair (connection bit and
// rhythm overrides), and accumulate into left/right sums gated by per-channel pan
// enables. The sums are saturated to SAMPLE_WIDTH and presented with clip flags.
//
// Handshake: sample_valid is a one-cycle strobe with no back-pressure. sample_l/r
// and clip_l/r change only in the cycle sample_valid is high and hold otherwise.
// The operator memory read is fire-and-forget: op_rd/op_rd_num in cycle t return
// op_rd_data in cycle t+1.
module stereo_channel_mixer #(
    parameter int NUM_CHANNELS = 9,
    parameter int OP_OUT_WIDTH = 13,
    parameter int SAMPLE_WIDTH = 16,
    parameter int RHYTHM_EN    = 1
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    sample_clk_en,
    input  logic                                    ops_done_pulse,
    input  logic                                    reg_wr_valid,
    input  logic [7:0]                              reg_wr_address,
    input  logic [7:0]                              reg_wr_data,
    output logic                                    op_rd,
    output logic [$clog2(2*NUM_CHANNELS)-1:0]       op_rd_num,
    input  logic signed [OP_OUT_WIDTH-1:0]          op_rd_data,
    output logic                                    busy,
    output logic                                    sample_valid,
    output logic signed [SAMPLE_WIDTH-1:0]          sample_l,
    output logic signed [SAMPLE_WIDTH-1:0]          sample_r,
    output logic                                    clip_l,
    output logic                                    clip_r,
    output logic [2:0]                              state_dbg
);

    localparam int OPN_W     = $clog2(2*NUM_CHANNELS);
    localparam int CH_IDX_W  = $clog2(NUM_CHANNELS);
    localparam int CH_W      = OP_OUT_WIDTH + 2;
    localparam int ACC_W     = OP_OUT_WIDTH + $clog2(NUM_CHANNELS) + 3;
    localparam bit RYT_OK    = (RHYTHM_EN != 0) && (NUM_CHANNELS >= 9);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2**(SAMPLE_WIDTH-1) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_SECOND = 3'd1,
        RD_FIRST  = 3'd2,
        ACC       = 3'd3,
        DONE      = 3'd4
    } state_t;

    state_t state, state_next;

    // Register file
    logic [NUM_CHANNELS-1:0] cnt, pan_l, pan_r;
    logic                    ryt;
    logic [7:0]              reg_idx;
    logic                    unused_data_bits;

    // Channel walk and datapath
    logic [CH_IDX_W-1:0]        ch_idx;
    logic [OPN_W-1:0]           first_op;
    logic [1:0]                 sub_idx;
    logic signed [CH_W-1:0]     b_reg;
    logic signed [ACC_W-1:0]    acc_l, acc_r;

    logic signed [CH_W-1:0]     a_ext, sum_ab, ch_val;
    logic signed [ACC_W-1:0]    contrib;
    logic                       last_ch;

    assign state_dbg        = state;
    assign busy             = (state != IDLE);
    assign reg_idx          = reg_wr_address - 8'hC0;
    assign unused_data_bits = ^{reg_wr_data[7:6], reg_wr_data[3:1]};
    assign last_ch          = (ch_idx == CH_IDX_W'(NUM_CHANNELS - 1));

    // Clamp an accumulator into the sample range; MSB of the result is the clip flag.
    function automatic logic [SAMPLE_WIDTH:0] saturate(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX)      return {1'b1, SAT_MAX[SAMPLE_WIDTH-1:0]};
        else if (v < SAT_MIN) return {1'b1, SAT_MIN[SAMPLE_WIDTH-1:0]};
        else                  return {1'b0, v[SAMPLE_WIDTH-1:0]};
    endfunction

    // Channel register writes; an ACC cycle sees the value from before any same-cycle write.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            pan_l <= '1;
            pan_r <= '1;
            ryt   <= 1'b0;
        end else if (reg_wr_valid) begin
            if (reg_wr_address == 8'hBD) ryt <= reg_wr_data[5];
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (reg_wr_address >= 8'hC0 && reg_idx == 8'(i)) begin
                    cnt[i]   <= reg_wr_data[0];
                    pan_l[i] <= reg_wr_data[4];
                    pan_r[i] <= reg_wr_data[5];
                end
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state and operator read request; a start-of-sample strobe aborts from anywhere.
    always_comb begin
        state_next = state;
        op_rd      = 1'b0;
        op_rd_num  = '0;
        case (state)
            IDLE:      if (ops_done_pulse) state_next = RD_SECOND;
            RD_SECOND: begin
                op_rd      = 1'b1;
                op_rd_num  = first_op + OPN_W'(3);
                state_next = RD_FIRST;
            end
            RD_FIRST: begin
                op_rd      = 1'b1;
                op_rd_num  = first_op;
                state_next = ACC;
            end
            ACC:       state_next = last_ch ? DONE : RD_SECOND;
            DONE:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
        if (sample_clk_en) state_next = IDLE;
    end

    // Channel output: connection bit selects a+b or b; rhythm channels double their output.
    always_comb begin
        a_ext  = {{2{op_rd_data[OP_OUT_WIDTH-1]}}, op_rd_data};
        sum_ab = a_ext + b_reg;
        ch_val = cnt[ch_idx] ? sum_ab : b_reg;
        if (RYT_OK && ryt) begin
            if (ch_idx == CH_IDX_W'(6))
                ch_val = b_reg <<< 1;
            else if (ch_idx == CH_IDX_W'(7) || ch_idx == CH_IDX_W'(8))
                ch_val = sum_ab <<< 1;
        end
        contrib = {{(ACC_W-CH_W-1){ch_val[CH_W-1]}}, ch_val, 1'b0};
    end

    // Channel walk, accumulation and output update.
    always_ff @(posedge clk) begin
        if (reset) begin
            ch_idx       <= '0;
            first_op     <= '0;
            sub_idx      <= '0;
            b_reg        <= '0;
            acc_l        <= '0;
            acc_r        <= '0;
            sample_l     <= '0;
            sample_r     <= '0;
            clip_l       <= 1'b0;
            clip_r       <= 1'b0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (sample_clk_en) begin
                acc_l <= '0;
                acc_r <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        acc_l    <= '0;
                        acc_r    <= '0;
                        ch_idx   <= '0;
                        first_op <= '0;
                        sub_idx  <= '0;
                    end
                    RD_FIRST: b_reg <= {{2{op_rd_data[OP_OUT_WIDTH-1]}}, op_rd_data};
                    ACC: begin
                        if (pan_l[ch_idx]) acc_l <= acc_l + contrib;
                        if (pan_r[ch_idx]) acc_r <= acc_r + contrib;
                        ch_idx <= ch_idx + CH_IDX_W'(1);
                        // Operators come in groups of six: three first ops then three second ops.
                        if (sub_idx == 2'd2) begin
                            sub_idx  <= 2'd0;
                            first_op <= first_op + OPN_W'(4);
                        end else begin
                            sub_idx  <= sub_idx + 2'd1;
                            first_op <= first_op + OPN_W'(1);
                        end
                    end
                    DONE: begin
                        {clip_l, sample_l} <= saturate(acc_l);
                        {clip_r, sample_r} <= saturate(acc_r);
                        sample_valid       <= 1'b1;
                        acc_l              <= '0;
                        acc_r              <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stereo_channel_mixer.sv
// Bench for stereo_channel_mixer: directed passes with hand-computed sums, an
// operator-memory model, and a scoreboard monitor that checks every sample strobe
// against the expected queue, including its arrival cycle.
module tb_stereo_channel_mixer;

    localparam int N  = 9;
    localparam int OW = 13;
    localparam int SW = 16;
    localparam int LAT = 3*N + 2;

    // Clock / reset
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic                  sample_clk_en = 1'b0;
    logic                  ops_done_pulse = 1'b0;
    logic                  reg_wr_valid = 1'b0;
    logic [7:0]            reg_wr_address = '0;
    logic [7:0]            reg_wr_data = '0;
    logic                  op_rd;
    logic [$clog2(2*N)-1:0] op_rd_num;
    logic signed [OW-1:0]  op_rd_data = '0;
    logic                  busy, sample_valid, clip_l, clip_r;
    logic signed [SW-1:0]  sample_l, sample_r;
    logic [2:0]            state_dbg;

    stereo_channel_mixer #(
        .NUM_CHANNELS(N), .OP_OUT_WIDTH(OW), .SAMPLE_WIDTH(SW), .RHYTHM_EN(1)
    ) dut (
        .clk(clk), .reset(reset), .sample_clk_en(sample_clk_en),
        .ops_done_pulse(ops_done_pulse), .reg_wr_valid(reg_wr_valid),
        .reg_wr_address(reg_wr_address), .reg_wr_data(reg_wr_data),
        .op_rd(op_rd), .op_rd_num(op_rd_num), .op_rd_data(op_rd_data),
        .busy(busy), .sample_valid(sample_valid), .sample_l(sample_l),
        .sample_r(sample_r), .clip_l(clip_l), .clip_r(clip_r), .state_dbg(state_dbg)
    );

    // Operator memory model: one-cycle read latency
    logic signed [OW-1:0] op_mem [0:2*N-1];
    always @(posedge clk) op_rd_data <= op_rd ? op_mem[op_rd_num] : '0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard
    int total = 0;
    int bad = 0;
    logic [2*SW+1:0] exp_q[$];
    int              exp_t[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [2*SW+1:0] pack(input int l, input int r, input bit cl, input bit cr);
        return {cl, cr, l[SW-1:0], r[SW-1:0]};
    endfunction

    // Monitor: every strobe must match the oldest expectation and arrive on time
    always @(negedge clk) begin
        if (sample_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_sample: got l=%0d r=%0d required no strobe", sample_l, sample_r);
            end else begin
                logic [2*SW+1:0] e;
                int t;
                e = exp_q.pop_front();
                t = exp_t.pop_front();
                check("sample", {clip_l, clip_r, sample_l, sample_r}, e);
                check("sample_cycle", cyc, t);
            end
        end
    end

    // Driver tasks
    task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        reg_wr_valid = 1'b1; reg_wr_address = a; reg_wr_data = d;
        @(negedge clk);
        reg_wr_valid = 1'b0;
    endtask

    task automatic set_all(input logic [7:0] d);
        for (int c = 0; c < N; c++) wr_reg(8'hC0 + 8'(c), d);
    endtask

    task automatic fill_ops(input int v);
        for (int i = 0; i < 2*N; i++) op_mem[i] = OW'(v);
    endtask

    // Issue ops_done_pulse and push the expected sample; returns in the cycle after the pulse.
    task automatic run_pass(input int l, input int r, input bit cl, input bit cr);
        @(negedge clk);
        ops_done_pulse = 1'b1;
        exp_q.push_back(pack(l, r, cl, cr));
        exp_t.push_back(cyc + LAT);
        @(negedge clk);
        ops_done_pulse = 1'b0;
    endtask

    task automatic pulse_only();
        @(negedge clk);
        ops_done_pulse = 1'b1;
        @(negedge clk);
        ops_done_pulse = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 80 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_pending", exp_q.size(), 0);
        exp_q.delete();
        exp_t.delete();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        fill_ops(0);
        repeat (3) @(negedge clk);
        // Reset state
        check("rst_sample_l", sample_l, 0);
        check("rst_sample_r", sample_r, 0);
        check("rst_clip", {clip_l, clip_r}, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_op_rd", op_rd, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;

        // All channels additive, both pans, ops=100: 9*2*200 = 3600; a pulse while busy is ignored
        set_all(8'h31);
        fill_ops(100);
        run_pass(3600, 3600, 0, 0);
        check("busy_in_pass", busy, 1);
        repeat (4) @(negedge clk);
        ops_done_pulse = 1'b1;
        @(negedge clk);
        ops_done_pulse = 1'b0;
        drain();
        repeat (LAT + 5) @(negedge clk);

        // Channel 0 only, left only, FM: second op (op 3) = -500 -> -1000 / 0
        set_all(8'h30);
        wr_reg(8'hC0, 8'h10);
        fill_ops(0);
        op_mem[3] = -13'sd500;
        run_pass(-1000, 0, 0, 0);
        drain();

        // Rhythm: ch6 second op (15)=300 -> 4*300; ch7 pair (13,16)=50 each -> 4*100
        wr_reg(8'hC0, 8'h30);
        wr_reg(8'hBD, 8'h20);
        fill_ops(0);
        op_mem[15] = 13'sd300;
        op_mem[13] = 13'sd50;
        op_mem[16] = 13'sd50;
        run_pass(1600, 1600, 0, 0);
        drain();
        // Same ops, rhythm off: 2*300 + 2*50 = 700
        wr_reg(8'hBD, 8'h00);
        run_pass(700, 700, 0, 0);
        drain();

        // Saturation both directions
        set_all(8'h31);
        fill_ops(4095);
        run_pass(32767, 32767, 1, 1);
        drain();
        fill_ops(-4096);
        run_pass(-32768, -32768, 1, 1);
        drain();

        // Abort at k+10: no strobe, idle next cycle, outputs keep last values
        fill_ops(100);
        pulse_only();
        repeat (9) @(negedge clk);
        sample_clk_en = 1'b1;
        @(negedge clk);
        sample_clk_en = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_hold", {clip_l, clip_r, sample_l, sample_r}, pack(-32768, -32768, 1, 1));
        repeat (LAT + 5) @(negedge clk);
        run_pass(3600, 3600, 0, 0);
        drain();

        // Abort and pulse in the same cycle: abort wins
        @(negedge clk);
        sample_clk_en = 1'b1;
        ops_done_pulse = 1'b1;
        @(negedge clk);
        sample_clk_en = 1'b0;
        ops_done_pulse = 1'b0;
        check("abort_pulse_busy", busy, 0);
        repeat (LAT + 5) @(negedge clk);

        // Pan write during channel 4: this pass unchanged, next pass ch0 left-only
        run_pass(3600, 3600, 0, 0);
        repeat (11) @(negedge clk);
        wr_reg(8'hC0, 8'h11);
        drain();
        run_pass(3600, 3200, 0, 0);
        drain();

        // Reset mid-pass returns to reset values; registers revert (cnt=0): 9*2*100 = 1800
        pulse_only();
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_op_rd", op_rd, 0);
        check("midrst_out", {clip_l, clip_r, sample_l, sample_r}, 0);
        reset = 1'b0;
        run_pass(1800, 1800, 0, 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
